writeback_stage: RTL and testbench

Parametrised MEM/WB pipeline register plus writeback result selection for the 32-bit RISC-V pipeline; successor to the two-input writeback mux. Captures memory-stage results each cycle, with stall and flush control. Selects among N result sources and performs byte/halfword load extraction with sign/zero extension. Drives the register-file write port and flags misaligned loads.

---
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result-source select, sub-word load extraction and misalignment flagging.
// Optional retire counter built only when WB_RETIRE_CNT_EN is defined; otherwise RetireCountW is tied to 0.
module writeback_stage #(
    parameter int XLEN   = 32,
    parameter int NSRC   = 4,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32,
    localparam int SW    = (NSRC > 2) ? $clog2(NSRC) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic [SW-1:0]     ResultSrcM,
    input  logic [2:0]        LoadTypeM,
    input  logic [1:0]        ByteOffM,
    input  logic [REG_AW-1:0] RdM,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   ReadDataM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [XLEN-1:0]   ImmExtM,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic [REG_AW-1:0] RdW,
    output logic [XLEN-1:0]   ResultW,
    output logic              MisalignW,
    output logic [CNT_W-1:0]  RetireCountW
);

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    logic              r_valid;
    logic              r_regwrite;
    logic [SW-1:0]     r_src;
    logic [2:0]        r_ltype;
    logic [1:0]        r_off;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_rdata;
    logic [XLEN-1:0]   r_pc4;
    logic [XLEN-1:0]   r_imm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || FlushW) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_src      <= '0;
            r_ltype    <= '0;
            r_off      <= '0;
            r_rd       <= '0;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
        end else if (!StallW) begin
            r_valid    <= ValidM;
            r_regwrite <= RegWriteM;
            r_src      <= ResultSrcM;
            r_ltype    <= LoadTypeM;
            r_off      <= ByteOffM;
            r_rd       <= RdM;
            r_alu      <= ALUResultM;
            r_rdata    <= ReadDataM;
            r_pc4      <= PCPlus4M;
            r_imm      <= ImmExtM;
        end
    end

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic            w_is_half;
    logic            w_is_word;
    logic            w_misalign;
    int unsigned     w_sel;

    always_comb begin
        w_byte = '0;
        case (r_off)
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];

        // Casting a signed value up to XLEN performs the sign extension.
        w_load = '0;
        case (r_ltype)
            LT_LB:   w_load = XLEN'($signed(w_byte));
            LT_LH:   w_load = XLEN'($signed(w_half));
            LT_LBU:  w_load = XLEN'(w_byte);
            LT_LHU:  w_load = XLEN'(w_half);
            default: w_load = XLEN'($signed(r_rdata[31:0]));
        endcase

        w_is_half = (r_ltype == LT_LH) || (r_ltype == LT_LHU);
        w_is_word = !((r_ltype == LT_LB) || (r_ltype == LT_LBU) || w_is_half);
        w_misalign = r_valid && (r_src == SW'(1)) &&
                     ((w_is_half && r_off[0]) || (w_is_word && (r_off != 2'd0)));

        w_sel   = 32'(r_src);
        ResultW = '0;
        if (w_sel < NSRC) begin
            case (w_sel)
                0:       ResultW = r_alu;
                1:       ResultW = w_load;
                2:       ResultW = r_pc4;
                3:       ResultW = r_imm;
                default: ResultW = '0;
            endcase
        end
    end

    assign ValidW    = r_valid;
    assign RdW       = r_rd;
    assign MisalignW = w_misalign;
    assign RegWriteW = r_valid && r_regwrite && (r_rd != '0) && !w_misalign;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    // A retire is counted on the edge that moves a good instruction out of W; flush does not cancel it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !StallW && !w_misalign) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign RetireCountW = r_retire_cnt;
`else
    assign RetireCountW = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against a transaction-level model of the W register and result rules.
module tb_writeback_stage;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LoadTypeM;
    logic [1:0]  ByteOffM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;

    logic             ValidW, RegWriteW, MisalignW;
    logic [4:0]       RdW;
    logic [31:0]      ResultW;
    logic [CNT_W-1:0] RetireCountW;

    logic             ValidW3, RegWriteW3, MisalignW3;
    logic [4:0]       RdW3;
    logic [31:0]      ResultW3;
    logic [CNT_W-1:0] RetireCountW3;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .NSRC(4), .REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM), .ByteOffM(ByteOffM),
        .RdM(RdM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .ImmExtM(ImmExtM), .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .MisalignW(MisalignW), .RetireCountW(RetireCountW)
    );

    // Three-source build: select value 3 must produce zero.
    writeback_stage #(.XLEN(32), .NSRC(3), .REG_AW(5), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM), .ByteOffM(ByteOffM),
        .RdM(RdM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .ImmExtM(ImmExtM), .ValidW(ValidW3), .RegWriteW(RegWriteW3), .RdW(RdW3), .ResultW(ResultW3),
        .MisalignW(MisalignW3), .RetireCountW(RetireCountW3)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference W-stage contents
    logic        m_valid, m_rw;
    logic [1:0]  m_src, m_off;
    logic [2:0]  m_lt;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdata, m_pc4, m_imm;
    int          m_retired;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    function automatic logic model_mis();
        logic half, word;
        half = (m_lt == 3'b001) || (m_lt == 3'b101);
        word = !(m_lt inside {3'b000, 3'b001, 3'b100, 3'b101});
        return m_valid && (m_src == 2'd1) && ((half && (m_off % 2 == 1)) || (word && m_off != 0));
    endfunction

    task automatic model_clear(input bit clr_cnt);
        m_valid = 0; m_rw = 0; m_src = 0; m_off = 0; m_lt = 0; m_rd = 0;
        m_alu = 0; m_rdata = 0; m_pc4 = 0; m_imm = 0;
        if (clr_cnt) m_retired = 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] res;
        logic        mis;
        logic [CNT_W-1:0] cnt;
        mis = model_mis();
        case (m_src)
            2'd0:    res = m_alu;
            2'd1:    res = ext_load(m_lt, m_off, m_rdata);
            2'd2:    res = m_pc4;
            default: res = m_imm;
        endcase
`ifdef WB_RETIRE_CNT_EN
        cnt = CNT_W'(m_retired % (1 << CNT_W));
`else
        cnt = '0;
`endif
        chk({tag, ".valid"}, 64'(ValidW), 64'(m_valid));
        chk({tag, ".regwrite"}, 64'(RegWriteW), 64'(m_valid && m_rw && m_rd != 0 && !mis));
        chk({tag, ".rd"}, 64'(RdW), 64'(m_rd));
        chk({tag, ".result"}, 64'(ResultW), 64'(res));
        chk({tag, ".misalign"}, 64'(MisalignW), 64'(mis));
        chk({tag, ".retire"}, 64'(RetireCountW), 64'(cnt));
        chk({tag, ".result_nsrc3"}, 64'(ResultW3), (m_src == 2'd3) ? 64'd0 : 64'(res));
    endtask

    // Advance the model with the inputs currently applied, then let the DUT take the edge.
    task automatic cycle();
        if (m_valid && !StallW && !model_mis()) m_retired++;
        if (FlushW) begin
            model_clear(0);
        end else if (!StallW) begin
            m_valid = ValidM; m_rw = RegWriteM; m_src = ResultSrcM; m_lt = LoadTypeM;
            m_off = ByteOffM; m_rd = RdM; m_alu = ALUResultM; m_rdata = ReadDataM;
            m_pc4 = PCPlus4M; m_imm = ImmExtM;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] lt,
                         input logic [1:0] off, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [31:0] pc4, input logic [31:0] imm);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt; ByteOffM = off; RdM = rd;
        ALUResultM = alu; ReadDataM = rdat; PCPlus4M = pc4; ImmExtM = imm;
    endtask

    task automatic pulse_reset(input string tag);
        #3 reset = 1'b1;
        #1;
        model_clear(1);
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    logic [2:0] lt_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic [2:0] lts [4]    = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0] offs [4]   = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic [31:0] exps [4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_DADA, 32'h0000_DADA};

    initial begin
        reset = 1'b1; StallW = 0; FlushW = 0;
        set_m(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear(1);
        #2 check_all("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        set_m(1, 1, 2'd0, 3'b010, 0, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
        cycle(); check_all("alu");
        chk("alu.result_const", 64'(ResultW), 64'hDEAD_BEEF);
        chk("alu.rd_const", 64'(RdW), 64'd5);

        for (int i = 0; i < 4; i++) begin
            set_m(1, 1, 2'd1, lts[i], offs[i], 5'd7, 0, 32'hDADA_80DA, 0, 0);
            cycle(); check_all("load");
            chk("load.result_const", 64'(ResultW), 64'(exps[i]));
        end

        set_m(1, 1, 2'd1, 3'b010, 2'd2, 5'd8, 0, 32'h1234_5678, 0, 0);
        cycle(); check_all("mis_lw");
        chk("mis_lw.flag_const", 64'(MisalignW), 64'd1);
        set_m(1, 1, 2'd1, 3'b001, 2'd3, 5'd8, 0, 32'h1234_5678, 0, 0);
        cycle(); check_all("mis_lh");

        set_m(1, 1, 2'd2, 3'b010, 0, 5'd9, 0, 0, 32'h0000_0104, 0);
        cycle(); check_all("pc4");
        StallW = 1;
        for (int i = 0; i < 3; i++) begin
            set_m(1, 1, 2'd0, 3'b010, 0, 5'(i + 1), $urandom, 0, $urandom, 0);
            cycle(); check_all("stall");
            chk("stall.result_const", 64'(ResultW), 64'h104);
        end
        pulse_reset("rst_in_stall");
        set_m(1, 1, 2'd2, 3'b010, 0, 5'd9, 0, 0, 32'h0000_0104, 0);
        StallW = 0;
        cycle(); check_all("pc4b");
        FlushW = 1; StallW = 1;
        cycle(); check_all("flush_stall");
        chk("flush.valid_const", 64'(ValidW), 64'd0);
        FlushW = 0; StallW = 0;

        set_m(1, 1, 2'd3, 3'b010, 0, 5'd0, 0, 0, 0, 32'hCAFE_0001);
        cycle(); check_all("rd0");
        chk("rd0.regwrite_const", 64'(RegWriteW), 64'd0);
        pulse_reset("rst_mid");

        for (int i = 0; i < 17; i++) begin
            set_m(1, 1, 2'd0, 3'b010, 0, 5'd3, 32'(i), 0, 0, 0);
            cycle();
        end
        set_m(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(); check_all("wrap");
`ifdef WB_RETIRE_CNT_EN
        chk("wrap.count_const", 64'(RetireCountW), 64'd1);
`else
        chk("wrap.count_const", 64'(RetireCountW), 64'd0);
`endif

        for (int i = 0; i < 1500; i++) begin
            StallW = ($urandom_range(0, 3) == 0);
            FlushW = ($urandom_range(0, 9) == 0);
            set_m($urandom_range(0, 4) != 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  lt_tab[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom, $urandom, $urandom);
            cycle(); check_all("rand");
            if (i % 300 == 299) pulse_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
